// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage.
//   stage_state_e : occupancy encoding (EMPTY / ONE / TWO)
//   CORE_NOP      : canonical NOP instruction word (addi x0, x0, 0)
//   *_payload_t   : per-stage payload layouts and their widths
package pipe_stage_elastic_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam logic [31:0] CORE_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } dec_ex_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [4:0]  rd;
    logic        we;
  } ex_mem_payload_t;

  localparam int unsigned DEC_EX_W = $bits(dec_ex_payload_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_payload_t);

endpackage

// File: rtl/pipe_skid_slot.sv
// Single payload + killed register used for both the main and skid slots.
// Ports:
//   clk, rst          : clock, async active-high reset
//   load              : capture d_data / d_killed
//   clear             : return to NOP_VALUE / not-killed (wins over load)
//   d_data, d_killed  : next payload and kill flag
//   q_data, q_killed  : held payload and kill flag
module pipe_skid_slot #(
  parameter int unsigned        DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_killed,
  output logic [DATA_W-1:0] q_data,
  output logic              q_killed
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data   <= NOP_VALUE;
      q_killed <= 1'b0;
    end else if (clear) begin
      q_data   <= NOP_VALUE;
      q_killed <= 1'b0;
    end else if (load) begin
      q_data   <= d_data;
      q_killed <= d_killed;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline stage: valid/ready handshake with a 2-entry skid
// buffer (main + skid), fully registered back-pressure, 1 beat/cycle.
// flush drops all held beats and the same-cycle input beat; in_kill turns
// the accepted beat into a NOP, keeping bits selected by KILL_KEEP_MASK.
// Optional: define PIPE_STAGE_PERF_EN to add stall_cnt / bubble_cnt.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   in_valid, in_ready, in_data    : upstream handshake and payload
//   in_kill                        : kill the accepted beat
//   flush                          : synchronous flush
//   out_valid, out_ready, out_data : downstream handshake and payload
//   out_killed                     : presented beat was killed
//   stall_cnt, bubble_cnt          : saturating perf counters (optional)
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned        DATA_W         = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE      = '0,
  parameter logic [DATA_W-1:0]  KILL_KEEP_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_kill,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_killed
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  stage_state_e      state, state_nxt;
  logic              accept, drain;
  logic [DATA_W-1:0] beat_data;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic [DATA_W-1:0] main_d_data, skid_q_data;
  logic              main_d_killed, skid_q_killed;

  // in_ready / out_valid come straight from the state register, so neither
  // has a combinational path from the handshake inputs.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign beat_data = in_kill ? ((in_data & KILL_KEEP_MASK) | (NOP_VALUE & ~KILL_KEEP_MASK))
                             : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_nxt  = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (drain) begin
            // Clearing main on the way to EMPTY keeps out_data at NOP_VALUE
            // without an output mux.
            state_nxt  = EMPTY;
            main_clear = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            skid_load = 1'b1;
          end
        end
        TWO: begin
          if (drain) begin
            state_nxt      = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_nxt  = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_d_data   = main_from_skid ? skid_q_data   : beat_data;
  assign main_d_killed = main_from_skid ? skid_q_killed : in_kill;

  pipe_skid_slot #(
    .DATA_W    (DATA_W),
    .NOP_VALUE (NOP_VALUE)
  ) u_main (
    .clk      (clk),
    .rst      (rst),
    .load     (main_load),
    .clear    (main_clear),
    .d_data   (main_d_data),
    .d_killed (main_d_killed),
    .q_data   (out_data),
    .q_killed (out_killed)
  );

  pipe_skid_slot #(
    .DATA_W    (DATA_W),
    .NOP_VALUE (NOP_VALUE)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .d_data   (beat_data),
    .d_killed (in_kill),
    .q_data   (skid_q_data),
    .q_killed (skid_q_killed)
  );

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      // out_killed is cleared whenever the stage is empty.
      if ((!out_valid || out_killed) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;
  import pipe_stage_elastic_pkg::*;

  localparam logic [31:0] NOP  = CORE_NOP;
  localparam logic [31:0] KEEP = 32'hFFFF_0000;

  typedef struct packed {
    logic [31:0] data;
    logic        killed;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_kill, flush;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_killed;
  logic [31:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
  int unsigned m_stall, m_bubble;
`endif

  beat_t q[$];
  int    vectors = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .DATA_W         (32),
    .NOP_VALUE      (NOP),
    .KILL_KEEP_MASK (KEEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_kill    (in_kill),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_killed (out_killed)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic beat_t make_beat(input logic [31:0] d, input logic k);
    beat_t b;
    b.data   = k ? ((d & KEEP) | (NOP & ~KEEP)) : d;
    b.killed = k;
    return b;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"},  64'(out_valid),  64'd0);
    check({tag, "_in_ready"},   64'(in_ready),   64'd1);
    check({tag, "_out_data"},   64'(out_data),   64'(NOP));
    check({tag, "_out_killed"}, 64'(out_killed), 64'd0);
  endtask

  // One cycle: drive inputs and check outputs at the falling edge, then
  // advance the scoreboard by what the coming rising edge will do.
  task automatic step(input logic v, input logic [31:0] d, input logic k,
                      input logic f, input logic r);
    int unsigned n;
    @(negedge clk);
    in_valid = v; in_data = d; in_kill = k; flush = f; out_ready = r;
    #1;
    n = q.size();
    check("out_valid", 64'(out_valid), 64'(n != 0));
    check("in_ready",  64'(in_ready),  64'(n < 2));
    if (n != 0) begin
      check("out_data",   64'(out_data),   64'(q[0].data));
      check("out_killed", 64'(out_killed), 64'(q[0].killed));
    end else begin
      check("empty_data",   64'(out_data),   64'(NOP));
      check("empty_killed", 64'(out_killed), 64'd0);
    end
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt",  64'(stall_cnt),  64'(m_stall));
    check("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
    if (n != 0 && !r) m_stall++;
    if (n == 0 || q[0].killed) m_bubble++;
`endif
    if (n != 0 && r) void'(q.pop_front());
    if (f) q.delete();
    else if (v && n < 2) q.push_back(make_beat(d, k));
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = '0; in_kill = 0; flush = 0; out_ready = 0;
`ifdef PIPE_STAGE_PERF_EN
    m_stall = 0; m_bubble = 0;
`endif
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // single beat, 1-cycle latency
    step(1, 32'h1234, 0, 0, 1);
    step(0, 32'h0,    0, 0, 1);
    step(0, 32'h0,    0, 0, 1);

    // A, B, C back-to-back with stalled output, then drain in order
    step(1, 32'hA, 0, 0, 1);
    step(1, 32'hB, 0, 0, 0);
    step(1, 32'hC, 0, 0, 0);
    step(1, 32'hC, 0, 0, 1);
    step(1, 32'hC, 0, 0, 1);
    step(0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 0, 0, 1);

    // kill keeps upper half, lower half from NOP; kill without accept ignored
    step(1, 32'hABCD_1234, 1, 0, 1);
    step(0, 32'h5555_5555, 1, 0, 1);
    step(1, 32'h1111_2222, 0, 0, 1);
    step(0, 32'h0, 0, 0, 1);

    // flush in TWO drops everything including the same-cycle beat
    step(1, 32'hD, 0, 0, 0);
    step(1, 32'hE, 1, 0, 0);
    step(1, 32'hF, 0, 1, 0);
    step(0, 32'h0, 0, 0, 0);
    // flush in ONE with a same-cycle drain
    step(1, 32'h10, 0, 0, 0);
    step(1, 32'h11, 0, 1, 1);
    step(0, 32'h0,  0, 0, 1);

    // stall one beat for 5 cycles, then flush (counters survive)
    step(1, 32'h20, 0, 0, 0);
    repeat (5) step(0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 0, 0, 1);

    // randomised traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);

    // asynchronous reset in state TWO, between edges
    step(1, 32'h30, 0, 0, 0);
    step(1, 32'h31, 0, 0, 0);
    step(0, 32'h0,  0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
`ifdef PIPE_STAGE_PERF_EN
    check("async_rst_stall",  64'(stall_cnt),  64'd0);
    check("async_rst_bubble", 64'(bubble_cnt), 64'd0);
    m_stall = 0; m_bubble = 0;
`endif
    q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    step(1, 32'h40, 0, 0, 1);
    step(0, 32'h0,  0, 0, 1);
    step(0, 32'h0,  0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
